// File: rtl/rd_ptr_ctrl_pkg.sv
// rd_ptr_ctrl_pkg -- shared pointer helpers for the async FIFO controllers.
// Holds the default geometry and the binary/Gray conversions so the read-
// and write-side controllers convert pointers identically.
// Conversions operate on a 32-bit container; callers zero-extend narrower
// pointers in and truncate the result back. Leading zeros leave the low
// bits of both conversions unchanged, so any width up to 32 works.
package rd_ptr_ctrl_pkg;

    localparam int PTR_WIDTH_DEF   = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GW              = 32;

    typedef logic [GW-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GW-1] = g[GW-1];
        for (int i = GW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// rd_ptr_ctrl_if -- read-side FIFO control bundle.
// slave  : the pointer controller (takes requests, drives pointers/flags).
// master : the consumer / environment (drives requests, reads status).
// Signals:
//   r_en, clr_underflow  : read request, sticky-underflow clear
//   g_write_ptr          : Gray write pointer from the write clock domain
//   ae_thresh            : almost-empty threshold (quasi-static)
//   b_read_ptr/g_read_ptr: binary / Gray read pointer
//   r_addr               : RAM read address
//   empty, almost_empty, r_level, underflow, r_valid : status
interface rd_ptr_ctrl_if
    import rd_ptr_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
);
    logic                 r_en;
    logic                 clr_underflow;
    logic [PTR_WIDTH:0]   g_write_ptr;
    logic [PTR_WIDTH:0]   ae_thresh;
    logic [PTR_WIDTH:0]   b_read_ptr;
    logic [PTR_WIDTH:0]   g_read_ptr;
    logic [PTR_WIDTH-1:0] r_addr;
    logic                 empty;
    logic                 almost_empty;
    logic [PTR_WIDTH:0]   r_level;
    logic                 underflow;
    logic                 r_valid;

    modport slave (
        input  r_en, clr_underflow, g_write_ptr, ae_thresh,
        output b_read_ptr, g_read_ptr, r_addr, empty, almost_empty,
               r_level, underflow, r_valid
    );

    modport master (
        output r_en, clr_underflow, g_write_ptr, ae_thresh,
        input  b_read_ptr, g_read_ptr, r_addr, empty, almost_empty,
               r_level, underflow, r_valid
    );
endinterface

// File: rtl/rd_ptr_ctrl_sync.sv
// ptr_sync -- multi-flop synchronizer for a Gray-coded pointer.
// Ports: r_clk (destination clock), r_rst (sync, active high),
//        d (asynchronous Gray input), q (synchronized output).
// STAGES must be at least 2. Only Gray values are safe to pass here since
// at most one bit changes per source update.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge r_clk) begin
        if (r_rst) stg <= '0;
        else       stg <= {stg[STAGES-2:0], d};
    end

    assign q = stg[STAGES-1];
endmodule

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl -- read-pointer controller of an asynchronous FIFO.
// Ports: r_clk (read clock), r_rst (sync, active high),
//        bus (rd_ptr_ctrl_if.slave): read request, foreign Gray write
//        pointer, almost-empty threshold, underflow clear in; binary/Gray
//        read pointer, RAM address, empty/almost_empty/level/underflow/
//        r_valid out.
// Flags are computed from the *next* pointer so empty rises on the same
// edge as the accept that drains the last entry (no extra read slips by).
module rd_ptr_ctrl
    import rd_ptr_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH   = PTR_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         r_clk,
    input  logic         r_rst,
    rd_ptr_ctrl_if.slave bus
);
    localparam int PW = PTR_WIDTH + 1;
    typedef logic [PW-1:0] ptr_t;

    ptr_t g_wptr_sync;
    ptr_t w_bin;
    ptr_t b_next;
    ptr_t g_next;
    ptr_t level_next;
    logic accept;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .d     (bus.g_write_ptr),
        .q     (g_wptr_sync)
    );

    always_comb begin
        accept     = bus.r_en & ~bus.empty;
        b_next     = bus.b_read_ptr + PW'(accept);
        g_next     = PW'(bin2gray(GW'(b_next)));
        w_bin      = PW'(gray2bin(GW'(g_wptr_sync)));
        // Modular difference: pointers carry one extra wrap bit, so this
        // spans 0..2**PTR_WIDTH without ambiguity.
        level_next = w_bin - b_next;
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            bus.b_read_ptr   <= '0;
            bus.g_read_ptr   <= '0;
            bus.r_level      <= '0;
            bus.empty        <= 1'b1;
            bus.almost_empty <= 1'b1;
            bus.underflow    <= 1'b0;
            bus.r_valid      <= 1'b0;
        end else begin
            bus.b_read_ptr   <= b_next;
            bus.g_read_ptr   <= g_next;
            bus.r_level      <= level_next;
            bus.empty        <= (g_wptr_sync == g_next);
            bus.almost_empty <= (level_next <= bus.ae_thresh);
            bus.r_valid      <= accept;
            // Setting wins over clearing so a same-cycle fault is never lost.
            if (bus.r_en && bus.empty)  bus.underflow <= 1'b1;
            else if (bus.clr_underflow) bus.underflow <= 1'b0;
        end
    end

    assign bus.r_addr = bus.b_read_ptr[PTR_WIDTH-1:0];
endmodule
